// File: rtl/l2_writeback_buffer_if.sv
// rtl/l2_writeback_buffer_if.sv - eviction, dmem write and load-forwarding signal bundle
// The L2/memory side drives through master; the buffer sits on slave.
interface l2_writeback_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              evict_valid;
    logic [6:0]        evict_opcode;
    logic [ADDR_W-1:0] evict_addr;
    logic [DATA_W-1:0] evict_data;
    logic              dmem_wr_en;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [ADDR_W-1:0] lookup_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output evict_valid, evict_opcode, evict_addr, evict_data, dmem_ready, lookup_addr,
        input  dmem_wr_en, dmem_addr, dmem_wdata, fwd_hit, fwd_data
    );

    modport slave (
        input  evict_valid, evict_opcode, evict_addr, evict_data, dmem_ready, lookup_addr,
        output dmem_wr_en, dmem_addr, dmem_wdata, fwd_hit, fwd_data
    );
endinterface

// File: rtl/l2_writeback_buffer.sv
// rtl/l2_writeback_buffer.sv - posted L2 write buffer with coalescing and load forwarding
// Entries drain in order to dmem; the head being written is locked against coalescing.
module l2_writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    l2_writeback_buffer_if.slave       bus,
    output logic                       buf_full,
    output logic                       buf_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [6:0] STORE_OP = 7'b0100011;

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              dmem_wr_en_q, dmem_wr_en_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

    logic              enq_req, push, pop, coal_hit, hit;
    logic [PTR_W-1:0]  coal_idx, head_sel, idx;
    logic [DATA_W-1:0] hit_data;

    always_comb begin
        valid_d      = valid_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        state_d      = state_q;
        dmem_wr_en_d = dmem_wr_en_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        push         = 1'b0;
        pop          = 1'b0;
        coal_hit     = 1'b0;
        coal_idx     = '0;
        hit          = 1'b0;
        hit_data     = '0;
        idx          = '0;
        enq_req      = bus.evict_valid && (bus.evict_opcode == STORE_OP);

        // Walk oldest to youngest so the last match found is the youngest.
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (valid_q[idx] && addr_q[idx] == bus.lookup_addr) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
            if (valid_q[idx] && addr_q[idx] == bus.evict_addr &&
                !(state_q == WRITE && idx == rd_ptr_q)) begin
                coal_hit = 1'b1;
                coal_idx = idx;
            end
        end

        if (enq_req) begin
            if (coal_hit) begin
                data_d[coal_idx] = bus.evict_data;
            end else if (count_q == CNT_W'(DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                push             = 1'b1;
                valid_d[wr_ptr_q] = 1'b1;
                addr_d[wr_ptr_q]  = bus.evict_addr;
                data_d[wr_ptr_q]  = bus.evict_data;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
        end

        // Entry to be presented next; a same-cycle coalesce into it must not be missed.
        head_sel = (state_q == WRITE) ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    dmem_wr_en_d = 1'b1;
                    dmem_addr_d  = addr_q[head_sel];
                    dmem_wdata_d = (enq_req && coal_hit && coal_idx == head_sel) ?
                                   bus.evict_data : data_q[head_sel];
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                if (bus.dmem_ready) begin
                    pop               = 1'b1;
                    valid_d[rd_ptr_q] = 1'b0;
                    rd_ptr_d          = rd_ptr_q + 1'b1;
                    if (count_q > CNT_W'(1)) begin
                        dmem_addr_d  = addr_q[head_sel];
                        dmem_wdata_d = (enq_req && coal_hit && coal_idx == head_sel) ?
                                       bus.evict_data : data_q[head_sel];
                    end else begin
                        dmem_wr_en_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            addr_q       <= '{default: '0};
            data_q       <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            dmem_wr_en_q <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            dmem_wr_en_q <= dmem_wr_en_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign buf_full       = (count_q == CNT_W'(DEPTH));
    assign buf_empty      = (count_q == '0);
    assign count          = count_q;
    assign overflow       = overflow_q;
    assign bus.dmem_wr_en = dmem_wr_en_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.fwd_hit    = hit;
    assign bus.fwd_data   = hit_data;
endmodule
